// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
// Holds the predictions decode has issued for in-flight branches in a small
// FIFO and compares the oldest one with the outcome reported by the memory
// stage. It drives the predictor update strobe, taken flag and address. On a
// misprediction it raises a one-cycle flush with the corrected fetch PC.
// Optional feature macro: BRANCH_STATS_EN adds saturating resolved-branch and
// misprediction counters. Without it the stat ports read zero and no counter
// flops exist.
module branch_resolution_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [31:0] pred_pc,
    input  logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    output logic        update_valid,
    output logic        update_taken,
    output logic [31:0] update_addr,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        queue_full,
    output logic        queue_empty,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
    } entry_t;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t           r_state;
    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_normal;
    logic             w_push;
    logic             w_pop;
    logic             w_mispred;
    entry_t           w_head;
    entry_t           w_new;
    logic [31:0]      w_redirect;

    // Occupancy flags come straight from the pre-edge count.
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign queue_full  = w_full;
    assign queue_empty = w_empty;

    // Both request kinds are ignored while a flush is in progress.
    assign w_normal   = (r_state == ST_NORMAL);
    assign w_push     = pred_valid & ~w_full & w_normal;
    assign w_pop      = res_valid & ~w_empty & w_normal;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_mispred  = w_pop & (res_taken != w_head.pred);
    assign w_redirect = res_taken ? w_head.target : (w_head.pc + 32'd4);

    assign w_new.pc     = pred_pc;
    assign w_new.target = pred_target;
    assign w_new.pred   = pred_taken;

    // Control FSM, FIFO storage/pointers and the registered predictor/flush outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_NORMAL;
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            update_valid <= 1'b0;
            update_taken <= 1'b0;
            update_addr  <= 32'h0;
            mispredict   <= 1'b0;
            redirect_pc  <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Strobes last one cycle. The address and redirect PC keep the
            // result of the most recent resolution.
            update_valid <= w_pop;
            mispredict   <= w_mispred;
            if (w_pop) begin
                update_taken <= res_taken;
                update_addr  <= w_head.pc;
                redirect_pc  <= w_redirect;
            end
            case (r_state)
                ST_NORMAL: begin
                    if (w_mispred) begin
                        // Younger entries and any same-cycle push are wrong-path.
                        r_state  <= ST_FLUSH;
                        r_rd_ptr <= {PTR_W{1'b0}};
                        r_wr_ptr <= {PTR_W{1'b0}};
                        r_count  <= {CNT_W{1'b0}};
                    end else begin
                        if (w_push) begin
                            r_mem[r_wr_ptr] <= w_new;
                            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                        end
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                        end
                        case ({w_push, w_pop})
                            2'b10:   r_count <= r_count + CNT_W'(1);
                            2'b01:   r_count <= r_count - CNT_W'(1);
                            default: r_count <= r_count;
                        endcase
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_NORMAL;
                end
                default: begin
                    r_state <= ST_NORMAL;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Saturating counters of resolved branches and mispredictions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= 32'h0;
            r_stat_mispredicts <= 32'h0;
        end else begin
            if (w_pop && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispred && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = 32'h0;
    assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Testbench for branch_resolution_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_branch_resolution_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_taken;
    logic        update_valid;
    logic        update_taken;
    logic [31:0] update_addr;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        queue_full;
    logic        queue_empty;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_resolution_unit #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .update_valid     (update_valid),
        .update_taken     (update_taken),
        .update_addr      (update_addr),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .queue_full       (queue_full),
        .queue_empty      (queue_empty),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    logic        m_flush = 1'b0;
    logic        m_uv    = 1'b0;
    logic        m_ut    = 1'b0;
    logic [31:0] m_ua    = 32'h0;
    logic        m_mis   = 1'b0;
    logic [31:0] m_rp    = 32'h0;
    logic [31:0] m_sb    = 32'h0;
    logic [31:0] m_sm    = 32'h0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Next-state of the model from the rules: one cycle of the branch queue.
    task automatic model_step(input logic rst, input logic pv, input logic pt,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input logic rv, input logic rt);
        ent_t e;
        bit   was_full;
        m_uv  = 1'b0;
        m_mis = 1'b0;
        if (rst) begin
            q.delete();
            m_flush = 1'b0;
            m_ut = 1'b0; m_ua = 32'h0; m_rp = 32'h0;
            m_sb = 32'h0; m_sm = 32'h0;
        end else if (m_flush) begin
            m_flush = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (rv && q.size() != 0) begin
                e = q.pop_front();
                m_uv  = 1'b1;
                m_ut  = rt;
                m_ua  = e.pc;
                m_mis = (rt != e.pred);
                m_rp  = rt ? e.tgt : e.pc + 32'd4;
                if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 32'd1;
                if (m_mis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 32'd1;
            end
            if (m_mis) begin
                q.delete();
                m_flush = 1'b1;
            end else if (pv && !was_full) begin
                e.pc = pc; e.tgt = tgt; e.pred = pt;
                q.push_back(e);
            end
        end
    endtask

    // Compare every DUT output with the model, one cycle after the edge.
    task automatic compare_all();
        check("update_valid", update_valid, m_uv);
        check("mispredict", mispredict, m_mis);
        if (m_uv) check("update_taken", update_taken, m_ut);
        check("update_addr", update_addr, m_ua);
        check("redirect_pc", redirect_pc, m_rp);
        check("queue_full", queue_full, (q.size() == DEPTH));
        check("queue_empty", queue_empty, (q.size() == 0));
`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, m_sb);
        check("stat_mispredicts", stat_mispredicts, m_sm);
`else
        check("stat_branches", stat_branches, 32'h0);
        check("stat_mispredicts", stat_mispredicts, 32'h0);
`endif
    endtask

    task automatic cycle(input logic rst, input logic pv, input logic pt,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic rv, input logic rt);
        reset = rst; pred_valid = pv; pred_taken = pt;
        pred_pc = pc; pred_target = tgt; res_valid = rv; res_taken = rt;
        model_step(rst, pv, pt, pc, tgt, rv, rt);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic push(input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
        cycle(1'b0, 1'b1, pt, pc, tgt, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic rt);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, rt);
    endtask

    logic [31:0] exp_addrs[4];

    initial begin
        reset = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0;
        pred_pc = 32'h0; pred_target = 32'h0; res_valid = 1'b0; res_taken = 1'b0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rst_empty", queue_empty, 32'd1);
        check("rst_full", queue_full, 32'd0);
        check("rst_uv", update_valid, 32'd0);
        check("rst_addr", update_addr, 32'h0);
        check("rst_redirect", redirect_pc, 32'h0);

        // Correct taken prediction
        push(1'b1, 32'h100, 32'h140);
        check("t1_not_empty", queue_empty, 32'd0);
        resolve(1'b1);
        check("t1_uv", update_valid, 32'd1);
        check("t1_addr", update_addr, 32'h100);
        check("t1_taken", update_taken, 32'd1);
        check("t1_mis", mispredict, 32'd0);
        check("t1_empty", queue_empty, 32'd1);
        check("t1_model_addr", m_ua, 32'h100);

        // Mispredict not-taken with younger entries, then a FLUSH cycle
        push(1'b1, 32'h200, 32'h280);
        push(1'b0, 32'h210, 32'h290);
        push(1'b1, 32'h220, 32'h2A0);
        resolve(1'b0);
        check("t2_mis", mispredict, 32'd1);
        check("t2_redirect", redirect_pc, 32'h204);
        check("t2_empty", queue_empty, 32'd1);
        check("t2_model_redirect", m_rp, 32'h204);
        cycle(1'b0, 1'b1, 1'b1, 32'h230, 32'h300, 1'b1, 1'b1);
        check("t2_flush_empty", queue_empty, 32'd1);
        check("t2_flush_uv", update_valid, 32'd0);
        check("t2_flush_mis", mispredict, 32'd0);

        // Full boundary, simultaneous push/pop while full, order across wrap
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'h400 + 32'(i * 4), 32'h440 + 32'(i * 4));
        end
        check("t3_full", queue_full, 32'd1);
        push(1'b1, 32'h500, 32'h540);
        check("t3_full_after_drop", queue_full, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'h600, 32'h640, 1'b1, 1'b0);
        check("t3_pp_uv", update_valid, 32'd1);
        check("t3_pp_addr", update_addr, 32'h400);
        check("t3_pp_count3", queue_full, 32'd0);
        check("t3_pp_model_cnt", 32'(q.size()), 32'd3);
        push(1'b0, 32'h600, 32'h640);
        check("t3_refull", queue_full, 32'd1);
        exp_addrs[0] = 32'h404; exp_addrs[1] = 32'h408;
        exp_addrs[2] = 32'h40C; exp_addrs[3] = 32'h600;
        for (int i = 0; i < 4; i++) begin
            resolve(1'b0);
            check("t3_order", update_addr, exp_addrs[i]);
            check("t3_order_mis", mispredict, 32'd0);
        end
        check("t3_drained", queue_empty, 32'd1);

        // Empty resolve: nothing happens, held values stay
        resolve(1'b1);
        check("t4_uv", update_valid, 32'd0);
        check("t4_empty", queue_empty, 32'd1);
        check("t4_redirect_held", redirect_pc, 32'h604);
        check("t4_addr_held", update_addr, 32'h600);

        // PC+4 wraps modulo 2^32
        push(1'b1, 32'hFFFF_FFFC, 32'h10);
        resolve(1'b0);
        check("t5_wrap_redirect", redirect_pc, 32'h0);
        check("t5_wrap_mis", mispredict, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Statistics
`ifdef BRANCH_STATS_EN
        force dut.r_stat_branches = 32'hFFFF_FFFE;
        #1;
        release dut.r_stat_branches;
        m_sb = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) push(1'b1, 32'h700 + 32'(i * 4), 32'h800);
        for (int i = 0; i < 3; i++) resolve(1'b1);
        check("t6_stat_sat", stat_branches, 32'hFFFF_FFFF);
`else
        check("t6_stat_b_zero", stat_branches, 32'h0);
        check("t6_stat_m_zero", stat_mispredicts, 32'h0);
`endif

        // Reset mid-stream with a mispredicting resolve pending
        push(1'b1, 32'h900, 32'h940);
        push(1'b1, 32'h904, 32'h944);
        push(1'b1, 32'h908, 32'h948);
        cycle(1'b1, 1'b1, 1'b0, 32'h90C, 32'h0, 1'b1, 1'b0);
        check("t7_empty", queue_empty, 32'd1);
        check("t7_mis", mispredict, 32'd0);
        check("t7_uv", update_valid, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 1)),
                  $urandom() & 32'hFFFF_FFFC,
                  $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
